// File: rtl/jio_pkg.sv
// Shared definitions for jcscpu IO devices: bus addresses, status byte layout
// and the read-FSM state encoding.
package jio_pkg;

  localparam logic [7:0] IO_ADDR_TTY = 8'h00;
  localparam logic [7:0] IO_ADDR_KBD = 8'h01;

  localparam int STAT_RDY     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_OVF     = 5;
  localparam int STAT_CNT_LSB = 0;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_DATA = 2'd1,
    RD_STAT = 2'd2
  } rd_state_t;

  function automatic logic [7:0] stat_byte(input logic       rdy,
                                           input logic       full,
                                           input logic       ovf,
                                           input logic [3:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_RDY]                       = rdy;
    s[STAT_FULL]                      = full;
    s[STAT_OVF]                       = ovf;
    s[STAT_CNT_LSB+3 : STAT_CNT_LSB]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/jfifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop completes in the same cycle.
module jfifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/jio_kbd.sv
// Keyboard/switch input device for jcscpu: queues operator bytes and hands
// them to the CPU through IN Data, with a status byte on IN Addr.
module jio_kbd
  import jio_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = IO_ADDR_KBD,
  parameter int         DEPTH    = 4,
  localparam int        CW       = $clog2(DEPTH) + 1
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [7:0] bus_in,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_da,
  input  logic       io_io,
  input  logic       key_push,
  input  logic [7:0] key_data,
  output logic [7:0] bus_out,
  output logic       rdy,
  output logic       full,
  output logic       ovf
);

  logic            w_addr_wr;
  logic            w_rd_data;
  logic            w_rd_stat;
  logic            w_pop;
  logic            w_ovf_set;
  logic            w_empty;
  logic            w_full;
  logic [7:0]      w_head;
  logic [CW-1:0]   w_count;
  logic [7:0]      w_cnt_ext;

  logic            r_addr_wr_q;
  logic            r_rd_data_q;
  logic            r_rd_stat_q;
  logic [7:0]      r_dev_sel;
  logic [7:0]      r_rd_snap;
  logic            r_armed;
  logic            r_ovf;
  rd_state_t       r_state;

  assign w_addr_wr = io_s & io_da & io_io;
  assign w_rd_data = io_e & ~io_da & ~io_io & (r_dev_sel == DEV_ADDR);
  assign w_rd_stat = io_e &  io_da & ~io_io & (r_dev_sel == DEV_ADDR);

  // Pop only what was shown on the bus; armed remembers whether a byte was.
  assign w_pop     = (r_state == RD_DATA) & ~w_rd_data & r_armed;
  assign w_ovf_set = key_push & w_full & ~w_pop;
  assign w_cnt_ext = 8'(w_count);

  jfifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (key_push),
    .pop   (w_pop),
    .din   (key_data),
    .dout  (w_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_wr_q <= 1'b0;
      r_rd_data_q <= 1'b0;
      r_rd_stat_q <= 1'b0;
      r_dev_sel   <= 8'h00;
    end else begin
      r_addr_wr_q <= w_addr_wr;
      r_rd_data_q <= w_rd_data;
      r_rd_stat_q <= w_rd_stat;
      if (w_addr_wr && !r_addr_wr_q) r_dev_sel <= bus_in;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RD_IDLE;
      r_rd_snap <= 8'h00;
      r_armed   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (w_rd_data && !r_rd_data_q) begin
            r_state   <= RD_DATA;
            r_rd_snap <= w_empty ? 8'h00 : w_head;
            r_armed   <= ~w_empty;
          end else if (w_rd_stat && !r_rd_stat_q) begin
            r_state   <= RD_STAT;
            r_rd_snap <= stat_byte(~w_empty, w_full, r_ovf, w_cnt_ext[3:0]);
          end
        end
        RD_DATA: begin
          if (!w_rd_data) begin
            r_state <= RD_IDLE;
            r_armed <= 1'b0;
          end
        end
        RD_STAT: begin
          if (!w_rd_stat) begin
            r_state <= RD_IDLE;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
      // A drop in the same cycle as the status-read clear must stay visible.
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  assign bus_out = (r_state != RD_IDLE) ? r_rd_snap : 8'h00;
  assign rdy     = ~w_empty;
  assign full    = w_full;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_jio_kbd.sv
// Directed bench for jio_kbd with a reference FIFO model and a queue of
// expected bus values checked when the DUT drives its read data.
module tb_jio_kbd;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic [7:0] bus_in;
  logic       io_s, io_e, io_da, io_io;
  logic       key_push;
  logic [7:0] key_data;
  logic [7:0] bus_out;
  logic       rdy, full, ovf;

  jio_kbd #(.DEV_ADDR(8'h01), .DEPTH(4)) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .bus_in   (bus_in),
    .io_s     (io_s),
    .io_e     (io_e),
    .io_da    (io_da),
    .io_io    (io_io),
    .key_push (key_push),
    .key_data (key_data),
    .bus_out  (bus_out),
    .rdy      (rdy),
    .full     (full),
    .ovf      (ovf)
  );

  always #5 CLK = ~CLK;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] m_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] m_sel;
  logic       m_ovf;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_rdy"},  {7'd0, rdy},  {7'd0, m_q.size() != 0});
    check({tag, "_full"}, {7'd0, full}, {7'd0, m_q.size() == 4});
    check({tag, "_ovf"},  {7'd0, ovf},  {7'd0, m_ovf});
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_q.size() < 4) m_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    key_data = b;
    key_push = 1'b1;
    tick(1);
    key_push = 1'b0;
    model_push(b);
  endtask

  task automatic out_addr(input logic [7:0] a);
    bus_in = a; io_da = 1'b1; io_io = 1'b1; io_s = 1'b1;
    tick(1);
    io_s = 1'b0; io_da = 1'b0; io_io = 1'b0;
    tick(1);
    m_sel = a;
  endtask

  // IN Data; optionally pushes a byte mid-read or in the cycle the read ends.
  task automatic in_data(input string tag, input bit push_mid, input bit push_fall,
                         input logic [7:0] pb);
    logic armed;
    armed = (m_sel == 8'h01) && (m_q.size() != 0);
    sb_q.push_back(armed ? m_q[0] : 8'h00);
    io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
    tick(1);
    if (push_mid) push(pb);
    tick(1);
    check(tag, bus_out, sb_q.pop_front());
    io_e = 1'b0;
    if (push_fall) begin
      key_data = pb;
      key_push = 1'b1;
    end
    tick(1);
    key_push = 1'b0;
    if (armed) void'(m_q.pop_front());
    if (push_fall) model_push(pb);
    check({tag, "_idle"}, bus_out, 8'h00);
    tick(1);
  endtask

  task automatic in_addr(input string tag);
    logic [7:0] st;
    st = {m_q.size() != 0, m_q.size() == 4, m_ovf, 1'b0, 4'(m_q.size())};
    sb_q.push_back((m_sel == 8'h01) ? st : 8'h00);
    io_da = 1'b1; io_io = 1'b0; io_e = 1'b1;
    tick(2);
    check(tag, bus_out, sb_q.pop_front());
    io_e = 1'b0;
    tick(1);
    io_da = 1'b0;
    if (m_sel == 8'h01) m_ovf = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; bus_in = 8'h00; io_s = 1'b0; io_e = 1'b0; io_da = 1'b0;
    io_io = 1'b0; key_push = 1'b0; key_data = 8'h00;
    m_sel = 8'h00; m_ovf = 1'b0;
    tick(2);
    check("reset_bus", bus_out, 8'h00);
    check_flags("reset");
    reset_n = 1'b1;
    tick(1);

    // Empty read returns zero and pops nothing
    out_addr(8'h01);
    in_data("empty_read", 1'b0, 1'b0, 8'h00);
    check_flags("empty_after");

    // Two bytes drained in order
    push(8'h41);
    push(8'h42);
    check_flags("two_queued");
    in_data("read_41", 1'b0, 1'b0, 8'h00);
    in_data("read_42", 1'b0, 1'b0, 8'h00);
    check_flags("drained");

    // Overflow and status byte
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    check_flags("overflow");
    in_addr("stat_E4");
    check_flags("ovf_cleared");
    in_addr("stat_C4");

    // Pop and push in the same cycle on a full FIFO: push accepted, no ovf
    in_data("full_pop_push", 1'b0, 1'b1, 8'h99);
    check_flags("pop_push");
    in_data("drain_1", 1'b0, 1'b0, 8'h00);
    in_data("drain_2", 1'b0, 1'b0, 8'h00);
    in_data("drain_3", 1'b0, 1'b0, 8'h00);
    in_data("drain_99", 1'b0, 1'b0, 8'h00);
    in_addr("stat_empty");

    // Byte arriving during an empty read is not popped unseen
    in_data("mid_push_read", 1'b1, 1'b0, 8'h55);
    check_flags("mid_push_kept");
    in_data("read_55", 1'b0, 1'b0, 8'h00);

    // Another device selected: bus stays quiet, nothing popped
    push(8'h11); push(8'h22); push(8'h33);
    out_addr(8'h00);
    in_data("tty_sel_read", 1'b0, 1'b0, 8'h00);
    out_addr(8'h01);
    in_addr("stat_83");

    // Reset in the middle of a read with two bytes queued
    in_data("read_11", 1'b0, 1'b0, 8'h00);
    io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
    tick(2);
    check("pre_reset_bus", bus_out, 8'h22);
    reset_n = 1'b0;
    #1;
    check("reset_async_bus", bus_out, 8'h00);
    m_q.delete(); m_ovf = 1'b0; m_sel = 8'h00;
    check_flags("reset_mid");
    io_e = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    push(8'h77);
    in_data("desel_after_reset", 1'b0, 1'b0, 8'h00);
    check_flags("kept_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
